// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and its round-robin picker:
// state encoding, parameter defaults and the rotation index helper.
package uart_tx_arbiter_pkg;

  // Encoding 2'd3 is unused and is steered back to ST_IDLE by the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_TIMEOUT    = 65535;
  localparam int DEF_CNT_W      = 16;

  localparam int IDX_W   = 3;
  localparam int MAX_REQ = 8;

  // Index examined at position 'offset' of a scan that starts just after 'last'.
  function automatic logic [IDX_W-1:0] rr_index(
    input logic [IDX_W-1:0] last,
    input int               offset,
    input int               n_req
  );
    int sum;
    sum = (int'(last) + 1 + offset) % n_req;
    return IDX_W'(sum);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning
// last+1, last+2, ... modulo N_REQ. Shared with the receive-side dispatcher.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_any_req
);

  logic [MAX_REQ-1:0] w_req_pad;
  logic [IDX_W-1:0]   w_cand_idx [N_REQ];
  logic [N_REQ-1:0]   w_cand_hit;

  always_comb begin
    w_req_pad              = '0;
    w_req_pad[N_REQ-1:0]   = i_req;
  end

  // Candidate gi is the requester at rotation distance gi+1 from the last grant.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign w_cand_idx[gi] = rr_index(i_last, gi, N_REQ);
      assign w_cand_hit[gi] = w_req_pad[w_cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the nearest hit is the one left standing.
  always_comb begin
    o_grant = i_last;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_cand_hit[k]) begin
        o_grant = w_cand_idx[k];
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters: round-robin grant,
// one byte per grant, Ack pulse per completed byte, inter-frame gap and watchdog.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_ack,
  output logic               o_err,
  output logic [2:0]         o_err_idx,
  output logic               o_busy,
  output logic               o_tx_en_sig,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_done_sig
);

  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  // A zero-length gap still costs the one edge that leaves ST_GAP.
  localparam logic [CNT_W-1:0] C_GAP_LAST     = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_LAST_RESET   = IDX_W'(N_REQ - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_grant;
  logic               r_tx_en;
  logic [7:0]         r_tx_data;
  logic [N_REQ-1:0]   r_ack;
  logic               r_err;
  logic [IDX_W-1:0]   r_err_idx;
  logic               r_busy;

  state_t             w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [IDX_W-1:0]   w_last_next;
  logic [IDX_W-1:0]   w_grant_next;
  logic               w_tx_en_next;
  logic [7:0]         w_tx_data_next;
  logic [N_REQ-1:0]   w_ack_next;
  logic               w_err_next;
  logic [IDX_W-1:0]   w_err_idx_next;
  logic               w_busy_next;

  logic [IDX_W-1:0]   w_pick;
  logic               w_any_req;
  logic [7:0]         w_bytes [MAX_REQ];
  logic [N_REQ-1:0]   w_ack_dec;

  uart_tx_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req     (i_req),
    .i_last    (r_last),
    .o_grant   (w_pick),
    .o_any_req (w_any_req)
  );

  // Byte lanes padded to the full index range so any 3-bit index is safe.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_bytes
      if (gi < N_REQ) begin : g_used
        assign w_bytes[gi] = i_req_data[8*gi +: 8];
      end else begin : g_pad
        assign w_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ack_dec
      assign w_ack_dec[gi] = (r_grant == IDX_W'(gi));
    end
  endgenerate

  // Saturating increment keeps the counter from ever wrapping.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_last_next    = r_last;
    w_grant_next   = r_grant;
    w_tx_en_next   = r_tx_en;
    w_tx_data_next = r_tx_data;
    w_ack_next     = '0;
    w_err_next     = 1'b0;
    w_err_idx_next = r_err_idx;

    case (r_state)
      ST_IDLE: begin
        w_tx_en_next = 1'b0;
        if (w_any_req) begin
          w_grant_next   = w_pick;
          w_tx_data_next = w_bytes[w_pick];
          w_tx_en_next   = 1'b1;
          w_cnt_next     = '0;
          w_state_next   = ST_SEND;
        end
      end

      ST_SEND: begin
        w_tx_en_next = 1'b1;
        // Completion takes priority over a watchdog expiry on the same edge.
        if (i_tx_done_sig) begin
          w_tx_en_next = 1'b0;
          w_ack_next   = w_ack_dec;
          w_last_next  = r_grant;
          w_cnt_next   = '0;
          w_state_next = ST_GAP;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_tx_en_next   = 1'b0;
          w_err_next     = 1'b1;
          w_err_idx_next = r_grant;
          w_last_next    = r_grant;
          w_cnt_next     = '0;
          w_state_next   = ST_GAP;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      ST_GAP: begin
        w_tx_en_next = 1'b0;
        if (r_cnt == C_GAP_LAST) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      default: begin
        w_tx_en_next = 1'b0;
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_last    <= C_LAST_RESET;
      r_grant   <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_last    <= w_last_next;
      r_grant   <= w_grant_next;
      r_tx_en   <= w_tx_en_next;
      r_tx_data <= w_tx_data_next;
      r_ack     <= w_ack_next;
      r_err     <= w_err_next;
      r_err_idx <= w_err_idx_next;
      r_busy    <= w_busy_next;
    end
  end

  assign o_ack       = r_ack;
  assign o_err       = r_err;
  assign o_err_idx   = r_err_idx;
  assign o_busy      = r_busy;
  assign o_tx_en_sig = r_tx_en;
  assign o_tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural transmitter stands in for
// tx_control_module, and a queue/rotation model predicts grants and bytes.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int GAP     = 16;
  localparam int TO      = 100;
  localparam int BIT_CYC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        err;
  logic [2:0]  err_idx;
  logic        busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        tx_line = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  bit          done_en = 1'b1;
  int          m_unstable = 0;
  logic [7:0]  rx_q  [$];
  logic [7:0]  exp_q [$];
  int          m_last;

  uart_tx_arbiter #(
    .N_REQ      (N),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TO),
    .CNT_W      (16)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_req_data    (req_data),
    .o_ack         (ack),
    .o_err         (err),
    .o_err_idx     (err_idx),
    .o_busy        (busy),
    .o_tx_en_sig   (tx_en),
    .o_tx_data     (tx_data),
    .i_tx_done_sig (tx_done)
  );

  always #5 clk = ~clk;

  // Transmitter: 11-bit frame (start, 8 data LSB-first, 2 stop), BIT_CYC clocks
  // per bit, one-cycle Done, then waits for En to drop before the next frame.
  initial begin
    bit         m_act;
    bit         m_wait;
    int         m_cyc;
    logic [10:0] m_frame;
    m_act = 1'b0;
    m_wait = 1'b0;
    m_cyc = 0;
    m_frame = '1;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        m_act = 1'b0;
        m_wait = 1'b0;
        m_cyc = 0;
        tx_done <= 1'b0;
        tx_line <= 1'b1;
      end else begin
        tx_done <= 1'b0;
        if (m_wait) begin
          if (tx_en !== 1'b1) m_wait = 1'b0;
        end else if (!m_act) begin
          if (tx_en === 1'b1) begin
            m_act = 1'b1;
            m_cyc = 0;
            m_frame = {2'b11, tx_data, 1'b0};
          end
        end else if (tx_en !== 1'b1) begin
          m_act = 1'b0;
        end else begin
          if (tx_data !== m_frame[8:1]) m_unstable++;
          m_cyc++;
          if (m_cyc == BIT_CYC * 11) begin
            m_act = 1'b0;
            m_wait = 1'b1;
            if (done_en) begin
              tx_done <= 1'b1;
              rx_q.push_back(m_frame[8:1]);
            end
          end
        end
        tx_line <= m_act ? m_frame[m_cyc / BIT_CYC] : 1'b1;
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int rr_next(input logic [3:0] m, input int last);
    int k;
    for (int i = 1; i <= N; i++) begin
      k = (last + i) % N;
      if (m[k]) return k;
    end
    return 0;
  endfunction

  task automatic wait_en();
    int n;
    n = 0;
    while (tx_en !== 1'b1 && n < 300) begin step(); n++; end
    chk("en_seen", {31'b0, tx_en}, 32'd1);
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (ack === 4'b0000 && n < 300) begin step(); n++; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin step(); n++; end
    chk("idle_seen", {31'b0, busy}, 32'd0);
  endtask

  // Serves every requester in 'mask' once, predicting the order by rotation.
  task automatic serve(input logic [3:0] mask, input logic [31:0] data, input bit chk_gap);
    logic [3:0] pend;
    int g;
    int n;
    pend = mask;
    req_data = data;
    req = req | mask;
    while (pend != 4'b0000) begin
      g = rr_next(pend, m_last);
      wait_en();
      chk("grant_data", {24'b0, tx_data}, {24'b0, data[8*g +: 8]});
      wait_ack();
      chk("ack_vec", {28'b0, ack}, 32'(1 << g));
      $display("frame: requester %0d byte %02h ack %b", g, data[8*g +: 8], ack);
      exp_q.push_back(data[8*g +: 8]);
      req[g] = 1'b0;
      pend[g] = 1'b0;
      m_last = g;
      if (chk_gap && pend != 4'b0000) begin
        n = 0;
        while (tx_en !== 1'b1 && n < 100) begin step(); n++; end
        chk("gap_cycles", n, GAP + 1);
      end
    end
  endtask

  initial begin
    logic [10:0] cap;
    logic [10:0] exp_line;
    logic [31:0] d;
    logic [3:0]  mask;
    int          n;

    rst = 1'b1;
    req = 4'b0000;
    req_data = 32'h0;
    m_last = N - 1;
    repeat (3) step();
    chk("rst_ack",     {28'b0, ack},     32'd0);
    chk("rst_err",     {31'b0, err},     32'd0);
    chk("rst_err_idx", {29'b0, err_idx}, 32'd0);
    chk("rst_busy",    {31'b0, busy},    32'd0);
    chk("rst_en",      {31'b0, tx_en},   32'd0);
    chk("rst_data",    {24'b0, tx_data}, 32'd0);
    rst = 1'b0;

    // All four requesting: order 0,1,2,3 with the gap between frames.
    serve(4'b1111, 32'h44332211, 1'b1);
    wait_idle();

    // Single requester from idle: one-cycle latency, line content, Ack, Busy.
    req_data = 32'h00A50000;
    req = 4'b0100;
    step();
    chk("t1_latency_en", {31'b0, tx_en}, 32'd1);
    chk("t1_data",       {24'b0, tx_data}, 32'hA5);
    step();
    for (int b = 0; b < 11; b++) begin
      step(); step();
      cap[b] = tx_line;
      step(); step();
    end
    exp_line = {2'b11, 8'hA5, 1'b0};
    chk("t1_line", {21'b0, cap}, {21'b0, exp_line});
    wait_ack();
    chk("t1_ack", {28'b0, ack}, 32'h4);
    $display("frame: requester 2 byte a5 ack %b", ack);
    exp_q.push_back(8'hA5);
    m_last = 2;
    req = 4'b0000;
    step();
    chk("t1_ack_pulse", {28'b0, ack}, 32'd0);
    repeat (GAP - 2) step();
    chk("t1_busy_hold", {31'b0, busy}, 32'd1);
    step();
    chk("t1_busy_fall", {31'b0, busy}, 32'd0);

    // Rotation: move last to 1, then 1001 -> 3 before 0, then 0001 -> 0.
    serve(4'b0010, 32'h00005A00, 1'b0);
    serve(4'b1001, 32'hC30000E7, 1'b0);
    serve(4'b0001, 32'h0000003C, 1'b0);

    // Watchdog: no Done, abort after TO cycles in SEND, then regrant.
    done_en = 1'b0;
    req_data = 32'h00960000;
    req = 4'b0100;
    wait_en();
    chk("wd_data", {24'b0, tx_data}, 32'h96);
    n = 0;
    while (tx_en === 1'b1 && n < 300) begin step(); n++; end
    chk("wd_en_cycles", n, TO);
    chk("wd_err",       {31'b0, err},     32'd1);
    chk("wd_err_idx",   {29'b0, err_idx}, 32'd2);
    chk("wd_no_ack",    {28'b0, ack},     32'd0);
    $display("abort: requester 2 err_idx %0d", err_idx);
    done_en = 1'b1;
    m_last = 2;
    step();
    chk("wd_err_pulse", {31'b0, err}, 32'd0);
    serve(4'b0100, 32'h00960000, 1'b0);

    // Reset mid-frame, then first grant goes to requester 0.
    req_data = 32'h7E000000;
    req = 4'b1000;
    wait_en();
    repeat (BIT_CYC * 5) step();
    rst = 1'b1;
    step();
    chk("mid_rst_en",   {31'b0, tx_en}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy},  32'd0);
    chk("mid_rst_ack",  {28'b0, ack},   32'd0);
    rst = 1'b0;
    m_last = N - 1;
    serve(4'b1001, 32'h7E000081, 1'b0);

    // Req[1] dropped during SEND completes; dropped before grant sends nothing.
    req_data = 32'h00006600;
    req = 4'b0010;
    wait_en();
    chk("drop_data", {24'b0, tx_data}, 32'h66);
    req = 4'b0000;
    wait_ack();
    chk("drop_ack", {28'b0, ack}, 32'h2);
    $display("frame: requester 1 byte 66 ack %b", ack);
    exp_q.push_back(8'h66);
    m_last = 1;
    step(); step();
    req = 4'b0010;
    repeat (3) step();
    req = 4'b0000;
    n = 0;
    repeat (60) begin
      step();
      if (tx_en === 1'b1) n++;
    end
    chk("drop_no_send", n, 0);

    // Randomised masks and bytes against the rotation model.
    for (int r = 0; r < 10; r++) begin
      mask = 4'($urandom_range(1, 15));
      d = $urandom;
      serve(mask, d, 1'b0);
    end
    wait_idle();
    repeat (4) step();

    chk("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk("rx_byte", {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    end
    chk("tx_data_stable", m_unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
